// File: rtl/rv32i_regfile_mp.sv
// rv32i_regfile_mp: parametrised RV32I register file with NRD read ports, one write port and a
// clear sequencer that zeroes x1..x(NREGS-1). Define REGFILE_BYPASS_EN to forward pending writes to reads.
module rv32i_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_ready,
    input  logic                  i_ce_read,
    input  logic                  i_ce_write,
    input  logic [NRD*AW-1:0]     i_rs_addr,
    input  logic [AW-1:0]         i_rd_addr,
    input  logic [XLEN-1:0]       i_rd,
    input  logic                  i_wr,
    output logic [NRD*XLEN-1:0]   o_rs
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    localparam logic [AW-1:0] CLR_FIRST = AW'(1);
    localparam logic [AW-1:0] CLR_LAST  = AW'(NREGS - 1);

    state_t              state, state_nx;
    logic [AW-1:0]       clr_idx, clr_idx_nx;
    logic [NRD*AW-1:0]   rs_addr_p0;
    logic                wr_en;
    logic [XLEN-1:0]     regs [NREGS];

    assign wr_en = i_wr && (i_rd_addr != '0) && i_ce_write && (state == S_READY);

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        case (state)
            S_CLEAR: begin
                clr_idx_nx = clr_idx + AW'(1);
                if (clr_idx == CLR_LAST) begin
                    state_nx   = S_READY;
                    clr_idx_nx = CLR_FIRST;
                end
            end
            S_READY: begin
                if (i_clear) begin
                    state_nx   = S_CLEAR;
                    clr_idx_nx = CLR_FIRST;
                end
            end
            default: begin
                state_nx   = S_CLEAR;
                clr_idx_nx = CLR_FIRST;
            end
        endcase
    end

    // Control and address-capture stage: o_ready follows the next state so it is high exactly in READY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_CLEAR;
            clr_idx    <= CLR_FIRST;
            o_ready    <= 1'b0;
            rs_addr_p0 <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
            o_ready <= (state_nx == S_READY);
            if (i_ce_read) begin
                rs_addr_p0 <= i_rs_addr;
            end
        end
    end

    // Storage is deliberately unreset: the clear sequencer rewrites it after every reset.
    always_ff @(posedge i_clk) begin
        if (state == S_CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_en) begin
            regs[i_rd_addr] <= i_rd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a_k;
        logic            hit;
        logic [XLEN-1:0] rd_k;

        assign a_k = rs_addr_p0[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_en && (a_k == i_rd_addr);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            rd_k = regs[a_k];
            if (state != S_READY || a_k == '0) begin
                rd_k = '0;
            end else if (hit) begin
                rd_k = i_rd;
            end
        end

        assign o_rs[k*XLEN +: XLEN] = rd_k;
    end

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Scoreboard bench for rv32i_regfile_mp: a default 32x32/2-port instance and a 16x64/3-port instance.
module tb_rv32i_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, NREGS=32, NRD=2
    logic        rst_n, clr_a, rdy_a, ce_rd_a, ce_wr_a, wr_a;
    logic [9:0]  rs_addr_a;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_a;
    logic [63:0] rs_a;

    // Instance B: XLEN=64, NREGS=16, NRD=3
    logic         rst_b_n, clr_b, rdy_b, ce_rd_b, ce_wr_b, wr_b;
    logic [11:0]  rs_addr_b;
    logic [3:0]   rd_addr_b;
    logic [63:0]  rd_b;
    logic [191:0] rs_b;

    rv32i_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_a), .o_ready(rdy_a),
        .i_ce_read(ce_rd_a), .i_ce_write(ce_wr_a), .i_rs_addr(rs_addr_a),
        .i_rd_addr(rd_addr_a), .i_rd(rd_a), .i_wr(wr_a), .o_rs(rs_a)
    );

    rv32i_regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_clear(clr_b), .o_ready(rdy_b),
        .i_ce_read(ce_rd_b), .i_ce_write(ce_wr_b), .i_rs_addr(rs_addr_b),
        .i_rd_addr(rd_addr_b), .i_rd(rd_b), .i_wr(wr_b), .o_rs(rs_b)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // sel: 0/1 = A read ports, 2 = A ready, 10..12 = B read ports, 13 = B ready
    function automatic logic [63:0] obs(input int sel);
        case (sel)
            0:       return {32'b0, rs_a[31:0]};
            1:       return {32'b0, rs_a[63:32]};
            2:       return {63'b0, rdy_a};
            10:      return rs_b[63:0];
            11:      return rs_b[127:64];
            12:      return rs_b[191:128];
            13:      return {63'b0, rdy_b};
            default: return 64'hx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [31:0] d);
        wr_a      = 1'b1;
        rd_addr_a = a;
        rd_a      = d;
        step();
        wr_a      = 1'b0;
    endtask

    task automatic set_rs_a(input logic [4:0] p0, input logic [4:0] p1);
        rs_addr_a = {p1, p0};
    endtask

    initial begin
        logic [31:0] byp_exp;
        logic [63:0] big;

        rst_n = 1'b0; clr_a = 1'b0; ce_rd_a = 1'b1; ce_wr_a = 1'b1; wr_a = 1'b1;
        rd_addr_a = 5'd5; rd_a = 32'hAAAA_5555; set_rs_a(5'd5, 5'd5);
        rst_b_n = 1'b0; clr_b = 1'b0; ce_rd_b = 1'b0; ce_wr_b = 1'b1; wr_b = 1'b0;
        rs_addr_b = '0; rd_addr_b = '0; rd_b = '0;

        // Reset state, then the power-up clear with writes to x5 held on
        push("rst_ready", 2, 64'd0);
        push("rst_rs0", 0, 64'd0);
        push("rst_rs1", 1, 64'd0);
        sample();
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            step();
            if (n == 31) wr_a = 1'b0;
            push($sformatf("pwrup_ready_e%0d", n), 2, (n == 31) ? 64'd1 : 64'd0);
            sample();
        end
        push("dropped_wr_x5_p0", 0, 64'd0);
        push("dropped_wr_x5_p1", 1, 64'd0);
        sample();

        // Plain write then read, x0 write ignored, capture hold when ce_read is low
        ce_rd_a = 1'b0;
        write_a(5'd7, 32'hDEAD_BEEF);
        set_rs_a(5'd0, 5'd7); ce_rd_a = 1'b1;
        step();
        ce_rd_a = 1'b0;
        push("x7_p1", 1, 64'hDEAD_BEEF);
        sample();
        write_a(5'd0, 32'h5555_AAAA);
        set_rs_a(5'd0, 5'd7); ce_rd_a = 1'b1;
        step();
        ce_rd_a = 1'b0;
        push("x0_p0", 0, 64'd0);
        sample();
        set_rs_a(5'd5, 5'd5);
        step();
        push("hold_p1", 1, 64'hDEAD_BEEF);
        sample();

        // Read concurrent with a write to the same register
        write_a(5'd9, 32'h0000_1111);
        set_rs_a(5'd9, 5'd9); ce_rd_a = 1'b1;
        step();
        ce_rd_a = 1'b0;
        wr_a = 1'b1; rd_addr_a = 5'd9; rd_a = 32'h0000_1234;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'h0000_1234;
`else
        byp_exp = 32'h0000_1111;
`endif
        push("x9_same_p0", 0, {32'b0, byp_exp});
        push("x9_same_p1", 1, {32'b0, byp_exp});
        sample();
        step();
        wr_a = 1'b0;
        push("x9_next_p0", 0, 64'h1234);
        push("x9_next_p1", 1, 64'h1234);
        sample();

        // Fill, then a requested clear (with an ignored re-request mid-sequence)
        for (int k = 1; k <= 31; k++) write_a(5'(k), 32'(k));
        set_rs_a(5'd17, 5'd31); ce_rd_a = 1'b1;
        step();
        ce_rd_a = 1'b0;
        push("fill_x17", 0, 64'd17);
        push("fill_x31", 1, 64'd31);
        sample();
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        push("clr_ready_drop", 2, 64'd0);
        push("clr_rs0", 0, 64'd0);
        push("clr_rs1", 1, 64'd0);
        sample();
        for (int n = 1; n <= 31; n++) begin
            step();
            clr_a = (n == 10);
            push($sformatf("clr_ready_e%0d", n), 2, (n == 31) ? 64'd1 : 64'd0);
            if (n < 31) push($sformatf("clr_rs0_e%0d", n), 0, 64'd0);
            sample();
        end
        clr_a = 1'b0;
        ce_rd_a = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            set_rs_a(5'(k), 5'(32 - k));
            step();
            push($sformatf("after_clr_x%0d", k), 0, 64'd0);
            push($sformatf("after_clr_x%0d", 32 - k), 1, 64'd0);
            sample();
        end
        ce_rd_a = 1'b0;

        // Reset asserted at clr_idx=10 of a clear; the restarted clear must finish
        write_a(5'd20, 32'h0000_0ABC);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        for (int n = 0; n < 9; n++) step();
        rst_n = 1'b0;
        push("midrst_ready", 2, 64'd0);
        push("midrst_rs0", 0, 64'd0);
        sample();
        step();
        push("midrst_ready_hold", 2, 64'd0);
        sample();
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            step();
            push($sformatf("reclr_ready_e%0d", n), 2, (n == 31) ? 64'd1 : 64'd0);
            sample();
        end
        set_rs_a(5'd20, 5'd0); ce_rd_a = 1'b1;
        step();
        ce_rd_a = 1'b0;
        push("reclr_x20", 0, 64'd0);
        sample();

        // Instance B: 16 entries, 3 ports, 64-bit data
        rst_b_n = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            push($sformatf("b_ready_e%0d", n), 13, (n == 15) ? 64'd1 : 64'd0);
            sample();
        end
        big = 64'hFFFF_0000_FFFF_0001;
        wr_b = 1'b1; rd_addr_b = 4'd15; rd_b = big;
        step();
        wr_b = 1'b0;
        rs_addr_b = {4'd15, 4'd15, 4'd15}; ce_rd_b = 1'b1;
        step();
        ce_rd_b = 1'b0;
        push("b_x15_p0", 10, big);
        push("b_x15_p1", 11, big);
        push("b_x15_p2", 12, big);
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_mp.md
# rv32i_regfile_mp

Parametrised successor of the RV32I base register file: `XLEN`-bit registers, `NREGS` entries and `NRD` read ports, with one synchronous write port. It adds a hardware clear sequencer that zeroes every register after reset or on request, and a ready flag that gates the pipeline. It sits between DECODE (read-address capture) and WRITEBACK (write), like the existing base regfile.

## Interface
- `XLEN`, 32, register width in bits.
- `NREGS`, 32, register count; power of two, 2..64; entry 0 is hardwired to zero. Localparam `AW` = $clog2(`NREGS`).
- `NRD`, 2, number of read ports, 1..4.

Ports:
- `i_clk` in 1: clock. One clock domain; all state changes on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_clear` in 1: request to zero all registers.
- `o_ready` out 1: high when the regfile is accepting writes and returning stored data.
- `i_ce_read` in 1: read-address capture enable (DECODE stage).
- `i_ce_write` in 1: write enable qualifier (after WRITEBACK).
- `i_rs_addr` in `NRD`*`AW`: read addresses; port k uses bits [k*AW +: AW].
- `i_rd_addr` in `AW`: write address.
- `i_rd` in `XLEN`: write data.
- `i_wr` in 1: write request.
- `o_rs` out `NRD`*`XLEN`: read data; port k uses bits [k*XLEN +: XLEN].

## Operation
- State machine with two states.
  - CLEAR: counter `clr_idx` runs 1..`NREGS`-1. Each cycle writes 0 to `regs[clr_idx]` and increments the counter. When `clr_idx`==`NREGS`-1 the next state is READY.
  - READY: normal operation. `i_clear`=1 moves to CLEAR with `clr_idx`=1.
- Reset values:
  - state = CLEAR, `clr_idx` = 1.
  - All captured read addresses = 0.
  - `o_ready` = 0, and `o_rs` = 0 on all ports.
- `o_ready` is a registered output, high exactly in READY.
- Write qualifier: `wr_en` = `i_wr` && `i_rd_addr`!=0 && `i_ce_write` && READY.
  - `wr_en` writes `i_rd` into `regs[i_rd_addr]` at the clock edge.
  - Writes while in CLEAR are dropped silently.
- Read capture: when `i_ce_read`=1, every port's address is registered at the clock edge, in either state. Otherwise the previous addresses are held.
- Read data for port k, from captured address `a_k`, is combinational:
  - CLEAR → 0.
  - `a_k`==0 → 0.
  - Bypass hit (see Configuration) → `i_rd`.
  - Otherwise → `regs[a_k]`.
- `i_clear` while already in CLEAR is ignored; the clear sequence is not restarted.
- Reset asserted mid-clear or mid-operation returns to the reset state immediately (asynchronously). Register contents are then rewritten by the new clear sequence.
- All ports are independent. Several ports may read the same address in the same cycle.

## Timing
- Clear sequence: exactly `NREGS`-1 cycles. With `NREGS`=32, `o_ready` rises on the 31st rising edge after `i_rst_n` deasserts.
- `i_clear` sampled high in READY: `o_ready` drops at the next edge and returns `NREGS`-1 edges later.
- Read latency: one edge for address capture, then combinational data.
- Write latency: data is visible through normal (non-bypass) reads from the cycle after the write edge.
- Write and clear in the same cycle (READY with `i_clear`=1 and `wr_en`=1): the write is performed, then the clear overwrites it during the sequence.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Bypass hit = `a_k`==`i_rd_addr` && `wr_en`.
  - Port k returns `i_rd` in the cycle the write is pending, so a read concurrent with a write yields the new value.
- `REGFILE_BYPASS_EN` undefined:
  - No forwarding. The same-cycle read returns the old `regs[a_k]`; the new value appears from the next cycle.
  - The DECODE/WRITEBACK hazard must then be covered by the pipeline's forwarding logic.

## Test plan
- Reset, then hold `i_wr`=1 with `i_rd_addr`=5, `i_ce_write`=1 → `o_ready`=0 for 31 edges and writes are dropped. After ready, `o_rs` for address 5 reads 0.
- READY: write 0xDEADBEEF to x7, then capture x7 on port 1 → port 1 = 0xDEADBEEF. Write to x0, then capture x0 → port 0 = 0.
- Capture x9 on both ports while writing 0x1234 to x9:
  - With `REGFILE_BYPASS_EN` → both ports = 0x1234 in the same cycle.
  - Without → old value that cycle, 0x1234 the next cycle.
- Fill x1..x31 with their own index, pulse `i_clear` → `o_ready` low for 31 cycles, `o_rs` = 0 during clear, every register reads 0 afterwards.
- Assert `i_rst_n`=0 at `clr_idx`=10 during a clear → `o_ready` stays 0. After deassert, a full 31-cycle clear runs and completes.
- `NREGS`=16, `NRD`=3, `XLEN`=64: write 64'hFFFF_0000_FFFF_0001 to x15 and read it on all three ports → identical values on all ports. Clear completes in 15 cycles.
